// File: rtl/sva_stim_gen.sv
// Stimulus player for SVA checker FSMs: replays a programmed vector sequence and counts verdicts.
// Optional build macro SVA_STIM_LFSR_EN adds rand_mode and LFSR-sourced stimulus.
module sva_stim_gen #(
  parameter int unsigned          SIG_WIDTH = 1,
  parameter int unsigned          DEPTH     = 16,
  parameter logic [SIG_WIDTH-1:0] IDLE_VAL  = '0,
  parameter int unsigned          CNT_WIDTH = 8
) (
  input  logic                       gclk,
  input  logic                       grst,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [SIG_WIDTH-1:0]       cfg_data,
  input  logic                       cfg_len_we,
  input  logic [$clog2(DEPTH):0]     cfg_len,
  output logic                       cfg_err,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       reps,
  input  logic [3:0]                 gap,
  input  logic                       stop,
`ifdef SVA_STIM_LFSR_EN
  input  logic                       rand_mode,
`endif
  output logic [SIG_WIDTH-1:0]       stim,
  output logic                       stim_valid,
  output logic                       sof,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  input  logic                       chk_succ,
  input  logic                       chk_fail,
  output logic [CNT_WIDTH-1:0]       pass_cnt,
  output logic [CNT_WIDTH-1:0]       fail_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StPlay, StGap, StDone} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [LW-1:0]          seq_len_q, seq_len_d;
  logic [CNT_WIDTH-1:0]   rep_left_q, rep_left_d;
  logic [3:0]             gap_len_q, gap_len_d;
  logic [3:0]             gap_ctr_q, gap_ctr_d;
  logic [SIG_WIDTH-1:0]   stim_q, stim_d;
  logic                   stim_valid_q, stim_valid_d;
  logic                   sof_q, sof_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [CNT_WIDTH-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0]   fail_cnt_q, fail_cnt_d;

  logic [SIG_WIDTH-1:0]   mem_q [DEPTH];
  logic                   mem_we;
  logic                   start_ok;
  logic                   last_elem;
  logic [SIG_WIDTH-1:0]   play_val;
  logic [CNT_WIDTH-1:0]   pass_base, fail_base;

`ifdef SVA_STIM_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        rand_mode_q, rand_mode_d;

  // Fibonacci LFSR, taps 16,14,13,11; free-running on every clock.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      lfsr_q      <= 16'hACE1;
      rand_mode_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      rand_mode_q <= rand_mode_d;
    end
  end

  assign play_val = rand_mode_q ? lfsr_q[SIG_WIDTH-1:0] : mem_q[idx_q];
`else
  assign play_val = mem_q[idx_q];
`endif

  assign start_ok  = (state_q == StIdle) && start && !stop && (seq_len_q != '0);
  assign last_elem = ({1'b0, idx_q} == (seq_len_q - LW'(1)));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seq_len_d    = seq_len_q;
    rep_left_d   = rep_left_q;
    gap_len_d    = gap_len_q;
    gap_ctr_d    = gap_ctr_q;
    stim_d       = IDLE_VAL;
    stim_valid_d = 1'b0;
    sof_d        = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    cfg_err_d    = 1'b0;
    mem_we       = 1'b0;
`ifdef SVA_STIM_LFSR_EN
    rand_mode_d  = rand_mode_q;
`endif

    unique case (state_q)
      StIdle: begin
        mem_we = cfg_we;
        if (cfg_len_we) begin
          if ((cfg_len != '0) && (cfg_len <= LW'(DEPTH))) begin
            seq_len_d = cfg_len;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (start && !stop) begin
          if (seq_len_q == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d    = StPlay;
            idx_d      = '0;
            rep_left_d = (reps == '0) ? '0 : reps - CNT_WIDTH'(1);
            gap_len_d  = gap;
`ifdef SVA_STIM_LFSR_EN
            rand_mode_d = rand_mode;
`endif
          end
        end
      end
      StPlay: begin
        stim_d       = play_val;
        stim_valid_d = 1'b1;
        sof_d        = (idx_q == '0);
        if (last_elem) begin
          if (rep_left_q == '0) begin
            state_d = StDone;
          end else if (gap_len_q == '0) begin
            rep_left_d = rep_left_q - CNT_WIDTH'(1);
            idx_d      = '0;
          end else begin
            state_d   = StGap;
            gap_ctr_d = gap_len_q;
          end
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StGap: begin
        if (gap_ctr_q == 4'd1) begin
          state_d    = StPlay;
          idx_d      = '0;
          rep_left_d = rep_left_q - CNT_WIDTH'(1);
        end else begin
          gap_ctr_d = gap_ctr_q - 4'd1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && (cfg_we || cfg_len_we)) begin
      cfg_err_d = 1'b1;
    end

    // stop overrides every transition, including end-of-pass and the done pulse.
    if (stop && (state_q != StIdle)) begin
      state_d      = StIdle;
      stim_d       = IDLE_VAL;
      stim_valid_d = 1'b0;
      sof_d        = 1'b0;
      done_d       = 1'b0;
      aborted_d    = 1'b1;
    end
  end

  // A clear coincident with a verdict still counts that verdict.
  always_comb begin
    pass_base  = start_ok ? '0 : pass_cnt_q;
    fail_base  = start_ok ? '0 : fail_cnt_q;
    pass_cnt_d = (chk_succ && (pass_base != '1)) ? pass_base + CNT_WIDTH'(1) : pass_base;
    fail_cnt_d = (chk_fail && (fail_base != '1)) ? fail_base + CNT_WIDTH'(1) : fail_base;
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      seq_len_q    <= '0;
      rep_left_q   <= '0;
      gap_len_q    <= '0;
      gap_ctr_q    <= '0;
      stim_q       <= IDLE_VAL;
      stim_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      seq_len_q    <= seq_len_d;
      rep_left_q   <= rep_left_d;
      gap_len_q    <= gap_len_d;
      gap_ctr_q    <= gap_ctr_d;
      stim_q       <= stim_d;
      stim_valid_q <= stim_valid_d;
      sof_q        <= sof_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      cfg_err_q    <= cfg_err_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  // Pattern memory is intentionally left unreset.
  always_ff @(posedge gclk) begin
    if (mem_we) begin
      mem_q[cfg_addr] <= cfg_data;
    end
  end

  assign stim       = stim_q;
  assign stim_valid = stim_valid_q;
  assign sof        = sof_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign cfg_err    = cfg_err_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_sva_stim_gen.sv
// Directed self-checking bench for sva_stim_gen (default build, LFSR feature disabled).
module tb_sva_stim_gen;

  logic       gclk;
  logic       grst;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [0:0] cfg_data;
  logic       cfg_len_we;
  logic [4:0] cfg_len;
  logic       cfg_err;
  logic       start;
  logic [7:0] reps;
  logic [3:0] gap;
  logic       stop;
  logic [0:0] stim;
  logic       stim_valid;
  logic       sof;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       chk_succ;
  logic       chk_fail;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;

  logic fail_drv;
  logic mon_en;
  logic mon_fail;

  int errors = 0;
  int checks = 0;

  sva_stim_gen #(
    .SIG_WIDTH(1),
    .DEPTH(16),
    .IDLE_VAL(1'b0),
    .CNT_WIDTH(8)
  ) dut (
    .gclk(gclk),
    .grst(grst),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_len_we(cfg_len_we),
    .cfg_len(cfg_len),
    .cfg_err(cfg_err),
    .start(start),
    .reps(reps),
    .gap(gap),
    .stop(stop),
    .stim(stim),
    .stim_valid(stim_valid),
    .sof(sof),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .chk_succ(chk_succ),
    .chk_fail(chk_fail),
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // Minimal checker model for the property "c never high": flags a failure one cycle later.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) mon_fail <= 1'b0;
    else      mon_fail <= mon_en & stim_valid & stim[0];
  end
  assign chk_fail = fail_drv | mon_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic write_mem(input int addr, input logic data);
    cfg_we   = 1'b1;
    cfg_addr = addr[3:0];
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic set_len(input int len);
    cfg_len_we = 1'b1;
    cfg_len    = len[4:0];
    tick();
    cfg_len_we = 1'b0;
  endtask

  task automatic start_play(input int r, input int g);
    start = 1'b1;
    reps  = r[7:0];
    gap   = g[3:0];
    tick();
    start = 1'b0;
  endtask

  // Runs until done/aborted or the cycle bound expires, collecting the played bits.
  task automatic play(input int bound, output int nvalid, output int nsof,
                      output bit got_done, output logic [15:0] bits);
    nvalid   = 0;
    nsof     = 0;
    got_done = 1'b0;
    bits     = '0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (stim_valid) begin
        nvalid++;
        bits = {bits[14:0], stim[0]};
      end
      if (sof) nsof++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (aborted) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       pat [4];
    int         nvalid;
    int         nsof;
    bit         got_done;
    logic [15:0] bits;

    pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;

    grst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_len_we = 1'b0;
    cfg_len = '0; start = 1'b0; reps = '0; gap = '0; stop = 1'b0; chk_succ = 1'b0;
    fail_drv = 1'b0; mon_en = 1'b0;
    #12;
    check("rst_stim", stim, 0);
    check("rst_valid", stim_valid, 0);
    check("rst_sof", sof, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    @(posedge gclk);
    #1 grst = 1'b0;

    // Zero length and start without a length are both rejected.
    set_len(0);
    check("len0_err", cfg_err, 1);
    start_play(1, 0);
    check("start_nolen_err", cfg_err, 1);
    check("start_nolen_busy", busy, 0);

    for (int i = 0; i < 4; i++) write_mem(i, pat[i]);
    set_len(4);
    check("len4_no_err", cfg_err, 0);

    // Single pass, cycle-accurate.
    start_play(1, 0);
    check("p1_busy_start", busy, 1);
    check("p1_valid_start", stim_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("p1_stim", stim, 32'(pat[k]));
      check("p1_valid", stim_valid, 1);
      check("p1_sof", sof, (k == 0) ? 1 : 0);
      check("p1_busy", busy, 1);
      check("p1_done_early", done, 0);
    end
    tick();
    check("p1_done", done, 1);
    check("p1_valid_end", stim_valid, 0);
    check("p1_busy_end", busy, 0);
    tick();
    check("p1_done_once", done, 0);

    // Three passes with a gap of two.
    start_play(3, 2);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        check("g_stim", stim, 32'(pat[k]));
        check("g_valid", stim_valid, 1);
        check("g_sof", sof, (k == 0) ? 1 : 0);
        check("g_done_early", done, 0);
      end
      if (p < 2) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          check("gap_valid", stim_valid, 0);
          check("gap_stim", stim, 0);
          check("gap_busy", busy, 1);
        end
      end
    end
    tick();
    check("g_done", done, 1);

    // Back-to-back passes and reps=0 treated as one pass.
    start_play(2, 0);
    play(30, nvalid, nsof, got_done, bits);
    check("b2b_nvalid", nvalid, 8);
    check("b2b_nsof", nsof, 2);
    check("b2b_bits", bits, 16'h0022);
    check("b2b_done", got_done, 1);
    start_play(0, 0);
    play(30, nvalid, nsof, got_done, bits);
    check("reps0_nvalid", nvalid, 4);
    check("reps0_done", got_done, 1);

    // Abort on the second element of the first pass.
    start_play(1, 0);
    tick();
    tick();
    check("stop_elem2_valid", stim_valid, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_aborted", aborted, 1);
    check("stop_valid", stim_valid, 0);
    check("stop_stim", stim, 0);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    tick();
    check("stop_aborted_once", aborted, 0);
    check("stop_no_done", done, 0);
    start_play(1, 0);
    play(30, nvalid, nsof, got_done, bits);
    check("replay_bits", bits, 16'h0002);
    check("replay_nvalid", nvalid, 4);
    check("replay_sof", nsof, 1);

    // start and stop together in IDLE: nothing happens.
    start = 1'b1; stop = 1'b1; reps = 8'd1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_aborted", aborted, 0);

    // Configuration writes while busy are ignored.
    start_play(1, 0);
    write_mem(2, 1'b0);
    check("busy_we_err", cfg_err, 1);
    set_len(2);
    check("busy_len_err", cfg_err, 1);
    play(30, nvalid, nsof, got_done, bits);
    check("busy_cfg_done", got_done, 1);
    set_len(17);
    check("len17_err", cfg_err, 1);
    tick();
    check("err_clears", cfg_err, 0);
    start_play(1, 0);
    play(30, nvalid, nsof, got_done, bits);
    check("cfg_kept_bits", bits, 16'h0002);
    check("cfg_kept_len", nvalid, 4);

    // Verdict counters.
    chk_succ = 1'b1; fail_drv = 1'b1;
    tick();
    chk_succ = 1'b0; fail_drv = 1'b0;
    check("both_pass", pass_cnt, 1);
    check("both_fail", fail_cnt, 1);
    chk_succ = 1'b1;
    repeat (300) tick();
    chk_succ = 1'b0;
    check("sat_pass", pass_cnt, 255);
    check("sat_fail_hold", fail_cnt, 1);
    chk_succ = 1'b1;
    start_play(1, 0);
    chk_succ = 1'b0;
    check("clr_with_pulse_pass", pass_cnt, 1);
    check("clr_fail", fail_cnt, 0);
    play(30, nvalid, nsof, got_done, bits);
    check("clr_play_done", got_done, 1);

    // Drive the checker model: no c -> no fail; c on the 3rd element -> one fail.
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) write_mem(i, 1'b0);
    start_play(1, 0);
    play(30, nvalid, nsof, got_done, bits);
    tick();
    tick();
    check("chk_nc_fail", fail_cnt, 0);
    write_mem(2, 1'b1);
    set_len(3);
    start_play(1, 0);
    play(30, nvalid, nsof, got_done, bits);
    check("chk_c_nvalid", nvalid, 3);
    tick();
    tick();
    check("chk_c_fail", fail_cnt, 1);
    check("chk_c_pass", pass_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
